// File: rtl/tank_pkg.sv
// Shared types and constants for the tank movement logic.
// Used by tank_motion_ctrl, key_dir_select and the player-2 / bullet blocks.
package tank_pkg;

    // Heading / key direction; values double as hit_* bit indices
    typedef enum logic [1:0] {
        DIR_A = 2'd0,
        DIR_D = 2'd1,
        DIR_S = 2'd2,
        DIR_W = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        PLAY  = 2'd0,
        DEAD  = 2'd1,
        GUARD = 2'd2
    } tank_state_t;

    // Keyboard scan codes
    localparam logic [7:0] KEY_A = 8'h04;
    localparam logic [7:0] KEY_D = 8'h07;
    localparam logic [7:0] KEY_S = 8'h16;
    localparam logic [7:0] KEY_W = 8'h1A;

    // Bit positions inside hit_block / hit_water ({W,S,D,A})
    localparam int HIT_A = 0;
    localparam int HIT_D = 1;
    localparam int HIT_S = 2;
    localparam int HIT_W = 3;

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_dir_select.sv
// Scans NUM_KEYS keycode slots and picks one movement direction with
// fixed priority A > D > S > W. Purely combinational.
module key_dir_select
    import tank_pkg::*;
#(
    parameter int NUM_KEYS = 4
) (
    input  logic [8*NUM_KEYS-1:0] keycodes,
    output logic                  key_vld,
    output dir_t                  key_dir
);

    logic prs_a, prs_d, prs_s, prs_w;

    // Flag each direction whose code appears in any slot
    always_comb begin
        prs_a = 1'b0;
        prs_d = 1'b0;
        prs_s = 1'b0;
        prs_w = 1'b0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (keycodes[8*i +: 8] == KEY_A) prs_a = 1'b1;
            if (keycodes[8*i +: 8] == KEY_D) prs_d = 1'b1;
            if (keycodes[8*i +: 8] == KEY_S) prs_s = 1'b1;
            if (keycodes[8*i +: 8] == KEY_W) prs_w = 1'b1;
        end
    end

    // Resolve simultaneous presses so only one axis ever moves
    always_comb begin
        key_vld = 1'b1;
        key_dir = DIR_W;
        if (prs_a)      key_dir = DIR_A;
        else if (prs_d) key_dir = DIR_D;
        else if (prs_s) key_dir = DIR_S;
        else if (prs_w) key_dir = DIR_W;
        else            key_vld = 1'b0;
    end

endmodule

// File: rtl/tank_motion_ctrl.sv
// Player tank movement with kill / respawn sequencing.
// Converts keyboard slots and per-direction collision flags into a
// registered position, motion vector and facing, one update per frame.
// Optional macro TANK_INVULN_EN adds the post-spawn GUARD (invulnerable)
// window; without it the tank goes straight from DEAD back to PLAY.
module tank_motion_ctrl
    import tank_pkg::*;
#(
    parameter int NUM_KEYS       = 4,
    parameter int SIZE           = 16,
    parameter int X_SPAWN        = 48,
    parameter int Y_SPAWN        = 464,
    parameter int X_MAX          = 639,
    parameter int Y_MAX          = 479,
    parameter int SPD_NORM       = 1,
    parameter int SPD_WATER      = 2,
    parameter int RESPAWN_FRAMES = 60,
    parameter int INVULN_FRAMES  = 120
) (
    input  logic                  frame_clk,
    input  logic                  Reset,
    input  logic                  gaming_on,
    input  logic [8*NUM_KEYS-1:0] keycodes,
    input  logic [3:0]            hit_block,
    input  logic [3:0]            hit_water,
    input  logic                  kill,
    output logic [9:0]            pos_x,
    output logic [9:0]            pos_y,
    output logic [9:0]            size,
    output logic [9:0]            motion_x,
    output logic [9:0]            motion_y,
    output logic [1:0]            facing,
    output logic                  alive,
    output logic                  invuln
);

    // One counter serves both the DEAD and GUARD timers
    localparam int CNT_W = $clog2(imax(RESPAWN_FRAMES, INVULN_FRAMES) + 1);
    localparam logic [CNT_W-1:0] DEAD_CNT0 = CNT_W'(RESPAWN_FRAMES - 1);
`ifdef TANK_INVULN_EN
    localparam logic [CNT_W-1:0] GUARD_CNT0 = CNT_W'(INVULN_FRAMES - 1);
`endif

    localparam logic [9:0]  X_SPAWN_V = 10'(X_SPAWN);
    localparam logic [9:0]  Y_SPAWN_V = 10'(Y_SPAWN);
    // Bounds are evaluated one bit wider so the sums cannot wrap
    localparam logic [10:0] SIZE_E    = 11'(SIZE);
    localparam logic [10:0] X_MAX_E   = 11'(X_MAX);
    localparam logic [10:0] Y_MAX_E   = 11'(Y_MAX);

    tank_state_t              state_r, state_nxt;
    logic        [CNT_W-1:0]  cnt_r, cnt_nxt;
    logic        [9:0]        pos_x_r, pos_y_r, pos_x_nxt, pos_y_nxt;
    logic signed [9:0]        mot_x_r, mot_y_r, mot_x_nxt, mot_y_nxt;
    dir_t                     facing_r, facing_nxt;

    logic                     key_vld;
    dir_t                     key_dir;
    logic                     blk, wet, mv_ok;
    logic        [9:0]        spd;
    logic        [9:0]        prd_x, prd_y;
    logic signed [9:0]        mv_x, mv_y;

    // True when a step of s from predicted position (px,py) stays on the field
    function automatic logic in_bounds(input dir_t d, input logic [9:0] px,
                                       input logic [9:0] py, input logic [9:0] s);
        logic [10:0] ex, ey, es;
        ex = {1'b0, px};
        ey = {1'b0, py};
        es = {1'b0, s};
        case (d)
            DIR_A:   return ex >= SIZE_E + es;
            DIR_D:   return ex + es + SIZE_E <= X_MAX_E;
            DIR_W:   return ey >= SIZE_E + es;
            default: return ey + es + SIZE_E <= Y_MAX_E;
        endcase
    endfunction

    key_dir_select #(
        .NUM_KEYS (NUM_KEYS)
    ) u_key_dir_select (
        .keycodes (keycodes),
        .key_vld  (key_vld),
        .key_dir  (key_dir)
    );

    // Candidate motion for the selected key: step size, legality, signed step
    always_comb begin
        blk = 1'b0;
        wet = 1'b0;
        case (key_dir)
            DIR_A:   begin blk = hit_block[HIT_A]; wet = hit_water[HIT_A]; end
            DIR_D:   begin blk = hit_block[HIT_D]; wet = hit_water[HIT_D]; end
            DIR_S:   begin blk = hit_block[HIT_S]; wet = hit_water[HIT_S]; end
            default: begin blk = hit_block[HIT_W]; wet = hit_water[HIT_W]; end
        endcase
        spd   = wet ? 10'(SPD_WATER) : 10'(SPD_NORM);
        prd_x = pos_x_r + $unsigned(mot_x_r);
        prd_y = pos_y_r + $unsigned(mot_y_r);
        mv_ok = key_vld && !blk && in_bounds(key_dir, prd_x, prd_y, spd);
        mv_x  = '0;
        mv_y  = '0;
        if (mv_ok) begin
            case (key_dir)
                DIR_A:   mv_x = -$signed(spd);
                DIR_D:   mv_x =  $signed(spd);
                DIR_W:   mv_y = -$signed(spd);
                default: mv_y =  $signed(spd);
            endcase
        end
    end

    // Kill / respawn sequencing and per-frame position/motion update
    always_comb begin
        state_nxt  = state_r;
        cnt_nxt    = cnt_r;
        pos_x_nxt  = pos_x_r;
        pos_y_nxt  = pos_y_r;
        mot_x_nxt  = mot_x_r;
        mot_y_nxt  = mot_y_r;
        facing_nxt = facing_r;
        if (gaming_on) begin
            case (state_r)
                PLAY: begin
                    if (kill) begin
                        // Kill beats any key press; the move of this frame is dropped
                        state_nxt = DEAD;
                        cnt_nxt   = DEAD_CNT0;
                        pos_x_nxt = X_SPAWN_V;
                        pos_y_nxt = Y_SPAWN_V;
                        mot_x_nxt = '0;
                        mot_y_nxt = '0;
                    end else begin
                        pos_x_nxt = prd_x;
                        pos_y_nxt = prd_y;
                        mot_x_nxt = mv_x;
                        mot_y_nxt = mv_y;
                        if (key_vld) facing_nxt = key_dir;
                    end
                end
                DEAD: begin
                    pos_x_nxt = X_SPAWN_V;
                    pos_y_nxt = Y_SPAWN_V;
                    mot_x_nxt = '0;
                    mot_y_nxt = '0;
                    if (cnt_r == '0) begin
`ifdef TANK_INVULN_EN
                        state_nxt = GUARD;
                        cnt_nxt   = GUARD_CNT0;
`else
                        state_nxt = PLAY;
`endif
                    end else begin
                        cnt_nxt = cnt_r - 1'b1;
                    end
                end
                GUARD: begin
                    // Moves like PLAY but kill has no effect
                    pos_x_nxt = prd_x;
                    pos_y_nxt = prd_y;
                    mot_x_nxt = mv_x;
                    mot_y_nxt = mv_y;
                    if (key_vld) facing_nxt = key_dir;
                    if (cnt_r == '0) state_nxt = PLAY;
                    else             cnt_nxt   = cnt_r - 1'b1;
                end
                default: state_nxt = PLAY;
            endcase
        end
    end

    // State, counter and kinematics registers
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state_r  <= PLAY;
            cnt_r    <= '0;
            pos_x_r  <= X_SPAWN_V;
            pos_y_r  <= Y_SPAWN_V;
            mot_x_r  <= '0;
            mot_y_r  <= '0;
            facing_r <= DIR_W;
        end else begin
            state_r  <= state_nxt;
            cnt_r    <= cnt_nxt;
            pos_x_r  <= pos_x_nxt;
            pos_y_r  <= pos_y_nxt;
            mot_x_r  <= mot_x_nxt;
            mot_y_r  <= mot_y_nxt;
            facing_r <= facing_nxt;
        end
    end

    assign pos_x    = pos_x_r;
    assign pos_y    = pos_y_r;
    assign size     = 10'(SIZE);
    assign motion_x = $unsigned(mot_x_r);
    assign motion_y = $unsigned(mot_y_r);
    assign facing   = facing_r;
    assign alive    = (state_r != DEAD);
`ifdef TANK_INVULN_EN
    assign invuln   = (state_r == GUARD);
`else
    assign invuln   = 1'b0;
`endif

endmodule

// File: tb/tb_tank_motion_ctrl.sv
// Directed bench for tank_motion_ctrl with an expected-value queue.
module tb_tank_motion_ctrl;

    localparam int RESPAWN = 60;
    localparam int INVULN  = 120;

    logic        frame_clk = 1'b0;
    logic        Reset;
    logic        gaming_on;
    logic [31:0] keycodes;
    logic [3:0]  hit_block;
    logic [3:0]  hit_water;
    logic        kill;
    logic [9:0]  pos_x, pos_y, size, motion_x, motion_y;
    logic [1:0]  facing;
    logic        alive, invuln;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] sb[$];
    int          alive_seen;

    tank_motion_ctrl dut (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .gaming_on (gaming_on),
        .keycodes  (keycodes),
        .hit_block (hit_block),
        .hit_water (hit_water),
        .kill      (kill),
        .pos_x     (pos_x),
        .pos_y     (pos_y),
        .size      (size),
        .motion_x  (motion_x),
        .motion_y  (motion_y),
        .facing    (facing),
        .alive     (alive),
        .invuln    (invuln)
    );

    always #5 frame_clk = ~frame_clk;

    task automatic tick;
        @(posedge frame_clk);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] v);
        sb.push_back(v);
    endtask

    task automatic check(input string tag, input logic [31:0] obs);
        logic [31:0] exp_v;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL %s scoreboard empty obs=%0d", tag, obs);
        end else begin
            exp_v = sb.pop_front();
            assert (obs === exp_v) else begin
                errors++;
                $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp_v);
            end
        end
    endtask

    task automatic set_key(input int slot, input logic [7:0] code);
        keycodes = '0;
        keycodes[8*slot +: 8] = code;
    endtask

    // Steer one axis to an exact target and come to rest there
    task automatic move_to(input bit ax_y, input int target);
        int cur, m, rem;
        bit done;
        done = 1'b0;
        for (int n = 0; n < 2000 && !done; n++) begin
            cur = ax_y ? int'(pos_y) : int'(pos_x);
            m   = ax_y ? int'($signed(motion_y)) : int'($signed(motion_x));
            rem = target - cur - m;
            if (cur == target && m == 0) begin
                done = 1'b1;
            end else begin
                keycodes = '0;
                if (rem > 0)      keycodes[7:0] = ax_y ? 8'h16 : 8'h07;
                else if (rem < 0) keycodes[7:0] = ax_y ? 8'h1A : 8'h04;
                tick;
            end
        end
        keycodes = '0;
        checks++;
        assert (done) else begin
            errors++;
            $error("FAIL move_to obs=timeout exp=%0d", target);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        Reset = 1'b1; gaming_on = 1'b0; keycodes = '0;
        hit_block = '0; hit_water = '0; kill = 1'b0;
        #12;
        push_exp(48); push_exp(464); push_exp(0); push_exp(0);
        push_exp(3);  push_exp(1);   push_exp(0); push_exp(16);
        check("rst_pos_x", pos_x);   check("rst_pos_y", pos_y);
        check("rst_mot_x", motion_x); check("rst_mot_y", motion_y);
        check("rst_facing", facing); check("rst_alive", alive);
        check("rst_invuln", invuln); check("size", size);

        // Key A in slot 2: motion first, position one frame later
        Reset = 1'b0; gaming_on = 1'b1; set_key(2, 8'h04);
        push_exp(10'h3FF); push_exp(0); push_exp(48);
        tick;
        check("a_mot_x", motion_x); check("a_facing", facing); check("a_pos_x_f1", pos_x);
        push_exp(47);
        tick;
        check("a_pos_x_f2", pos_x);

        move_to(1'b0, 100);
        move_to(1'b1, 200);
        push_exp(100); push_exp(200);
        check("at_x", pos_x); check("at_y", pos_y);

        // W through water: double step
        set_key(0, 8'h1A); hit_water = 4'b1000;
        push_exp(10'h3FE); push_exp(0); push_exp(200);
        tick;
        check("w_mot_y", motion_y); check("w_mot_x", motion_x); check("w_pos_y0", pos_y);
        push_exp(198); tick; check("w_pos_y1", pos_y);
        push_exp(196); tick; check("w_pos_y2", pos_y);
        keycodes = '0; hit_water = '0;
        tick;
        push_exp(194); push_exp(0);
        tick;
        check("stop_pos_y", pos_y); check("stop_mot_y", motion_y);

        // D into a wall: facing turns, no motion
        set_key(1, 8'h07); hit_block = 4'b0010;
        push_exp(0); push_exp(1);
        tick;
        check("blk_mot_x", motion_x); check("blk_facing", facing);
        push_exp(100);
        tick;
        check("blk_pos_x", pos_x);
        hit_block = '0; keycodes = '0;

        // Left boundary: tank stops with its edge at column 0
        move_to(1'b0, 18);
        set_key(0, 8'h04);
        push_exp(10'h3FF); push_exp(18);
        tick;
        check("lb_mot_f1", motion_x); check("lb_pos_f1", pos_x);
        push_exp(17); tick; check("lb_pos_f2", pos_x);
        push_exp(16); push_exp(0);
        tick;
        check("lb_pos_f3", pos_x); check("lb_mot_f3", motion_x);
        tick; tick;
        push_exp(16); push_exp(0); push_exp(0);
        tick;
        check("lb_pos_hold", pos_x); check("lb_mot_hold", motion_x); check("lb_facing", facing);

        // Kill while moving, with D held: kill wins
        set_key(0, 8'h07);
        tick;
        kill = 1'b1;
        push_exp(0); push_exp(48); push_exp(464); push_exp(0);
        tick;
        check("kill_alive", alive); check("kill_pos_x", pos_x);
        check("kill_pos_y", pos_y); check("kill_mot_x", motion_x);
        kill = 1'b0;
        alive_seen = 0;
        for (int i = 0; i < RESPAWN - 1; i++) begin
            tick;
            if (alive) alive_seen++;
        end
        push_exp(0); push_exp(0); push_exp(48); push_exp(0);
        check("dead_alive_cnt", alive_seen); check("dead_alive", alive);
        check("dead_pos_x", pos_x); check("dead_mot_x", motion_x);
        keycodes = '0;
`ifdef TANK_INVULN_EN
        push_exp(1); push_exp(1);
        tick;
        check("spawn_alive", alive); check("spawn_invuln", invuln);
        kill = 1'b1;
        push_exp(1); push_exp(1);
        tick;
        check("guard_kill_alive", alive); check("guard_kill_invuln", invuln);
        kill = 1'b0;
        for (int i = 0; i < INVULN - 2; i++) tick;
        push_exp(1);
        check("guard_end_invuln", invuln);
        push_exp(0); push_exp(1);
        tick;
        check("play_invuln", invuln); check("play_alive", alive);
`else
        push_exp(1); push_exp(0);
        tick;
        check("spawn_alive", alive); check("spawn_invuln", invuln);
        tick; tick;
        push_exp(0); push_exp(1);
        check("play_invuln", invuln); check("play_alive", alive);
`endif

        // Two keys at once: D outranks W
        keycodes = 32'h0000_071A;
        push_exp(1); push_exp(1); push_exp(0);
        tick;
        check("prio_facing", facing); check("prio_mot_x", motion_x); check("prio_mot_y", motion_y);
        push_exp(49); tick; check("prio_pos_x", pos_x);
        gaming_on = 1'b0;
        for (int i = 0; i < 5; i++) tick;
        push_exp(49); push_exp(1);
        check("freeze_pos_x", pos_x); check("freeze_mot_x", motion_x);
        gaming_on = 1'b1;
        push_exp(50); tick; check("thaw_pos_x", pos_x);

        // Counter freezes while gaming_on is low during DEAD
        keycodes = '0; kill = 1'b1;
        push_exp(0); tick; check("k2_alive", alive);
        kill = 1'b0; gaming_on = 1'b0;
        for (int i = 0; i < 30; i++) tick;
        gaming_on = 1'b1;
        for (int i = 0; i < RESPAWN - 1; i++) tick;
        push_exp(0); check("k2_dead_end", alive);
        push_exp(1); tick; check("k2_respawn", alive);

        // Asynchronous reset mid-GUARD (or PLAY) and mid-DEAD
        #1; Reset = 1'b1; #1;
        push_exp(0); push_exp(3); push_exp(1);
        check("rstg_invuln", invuln); check("rstg_facing", facing); check("rstg_alive", alive);
        Reset = 1'b0;
        tick;
        kill = 1'b1; tick; kill = 1'b0;
        for (int i = 0; i < 10; i++) tick;
        push_exp(0); check("rstd_pre_alive", alive);
        #1; Reset = 1'b1; #1;
        push_exp(1); push_exp(48); push_exp(464);
        check("rstd_alive", alive); check("rstd_pos_x", pos_x); check("rstd_pos_y", pos_y);
        Reset = 1'b0;
        tick;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
